// File: rtl/wb_write_arbiter_if.sv
// Writeback bundle: ALU and load result inputs, regfile write port, and the
// decode-side forwarding lookup.
interface wb_write_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_alu_valid;
    logic [4:0]      i_alu_rd;
    logic [XLEN-1:0] i_alu_data;
    logic            o_alu_ready;
    logic            i_ld_valid;
    logic [4:0]      i_ld_rd;
    logic [XLEN-1:0] i_ld_data;
    logic [4:0]      o_wr_addr;
    logic [XLEN-1:0] o_wr_data;
    logic            o_reg_write;
    logic [4:0]      i_rs1_addr;
    logic [4:0]      i_rs2_addr;
    logic            o_rs1_fwd_valid;
    logic [XLEN-1:0] o_rs1_fwd_data;
    logic            o_rs2_fwd_valid;
    logic [XLEN-1:0] o_rs2_fwd_data;
    logic [31:0]     o_pending_mask;

    modport master (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        output o_alu_ready,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        output o_wr_addr, o_wr_data, o_reg_write,
        input  i_rs1_addr, i_rs2_addr,
        output o_rs1_fwd_valid, o_rs1_fwd_data,
        output o_rs2_fwd_valid, o_rs2_fwd_data,
        output o_pending_mask
    );

    modport slave (
        output i_alu_valid, i_alu_rd, i_alu_data,
        input  o_alu_ready,
        output i_ld_valid, i_ld_rd, i_ld_data,
        input  o_wr_addr, o_wr_data, o_reg_write,
        output i_rs1_addr, i_rs2_addr,
        input  o_rs1_fwd_valid, o_rs1_fwd_data,
        input  o_rs2_fwd_valid, o_rs2_fwd_data,
        input  o_pending_mask
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter: loads win, deferred ALU results drain in order
// from a small FIFO that also feeds forwarding and the pending-rd mask.
module wb_write_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               i_reset,
    wb_write_arbiter_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;

    ptr_t            head;
    ptr_t            tail;
    logic [AW:0]     count;
    logic [4:0]      buf_rd   [DEPTH];
    logic [XLEN-1:0] buf_data [DEPTH];

    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;

    logic alu_ready;
    logic alu_live;
    logic ld_live;
    logic buf_empty;
    logic do_pop;
    logic do_push;

    // Ready depends only on the registered count, never on this cycle's inputs.
    assign alu_ready = (count < DEPTH_C);
    assign buf_empty = (count == '0);
    assign alu_live  = bus.i_alu_valid & alu_ready & (bus.i_alu_rd != 5'd0);
    assign ld_live   = bus.i_ld_valid & (bus.i_ld_rd != 5'd0);
    assign do_pop    = ~ld_live & ~buf_empty;
    // An accepted ALU result bypasses the buffer only when nothing else is writing.
    assign do_push   = alu_live & (ld_live | ~buf_empty);

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (ld_live) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.i_ld_rd;
                wr_data <= bus.i_ld_data;
            end else if (!buf_empty) begin
                wr_en   <= 1'b1;
                wr_addr <= buf_rd[head];
                wr_data <= buf_data[head];
            end else if (alu_live) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.i_alu_rd;
                wr_data <= bus.i_alu_data;
            end else begin
                wr_en   <= 1'b0;
            end
            if (do_push) tail <= tail + ptr_t'(1);
            if (do_pop)  head <= head + ptr_t'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_rd[tail]   <= bus.i_alu_rd;
            buf_data[tail] <= bus.i_alu_data;
        end
    end

    logic            f1_valid;
    logic [XLEN-1:0] f1_data;
    logic            f2_valid;
    logic [XLEN-1:0] f2_data;
    logic [31:0]     pending;
    ptr_t            idx;

    // Scan oldest to youngest so later hits override earlier ones.
    always_comb begin
        f1_valid = 1'b0;
        f1_data  = '0;
        f2_valid = 1'b0;
        f2_data  = '0;
        pending  = '0;
        idx      = head;
        if (wr_en && wr_addr == bus.i_rs1_addr && bus.i_rs1_addr != 5'd0) begin
            f1_valid = 1'b1;
            f1_data  = wr_data;
        end
        if (wr_en && wr_addr == bus.i_rs2_addr && bus.i_rs2_addr != 5'd0) begin
            f2_valid = 1'b1;
            f2_data  = wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + ptr_t'(i);
            if ((AW+1)'(i) < count) begin
                pending[buf_rd[idx]] = 1'b1;
                if (buf_rd[idx] == bus.i_rs1_addr && bus.i_rs1_addr != 5'd0) begin
                    f1_valid = 1'b1;
                    f1_data  = buf_data[idx];
                end
                if (buf_rd[idx] == bus.i_rs2_addr && bus.i_rs2_addr != 5'd0) begin
                    f2_valid = 1'b1;
                    f2_data  = buf_data[idx];
                end
            end
        end
    end

    assign bus.o_alu_ready     = alu_ready;
    assign bus.o_reg_write     = wr_en;
    assign bus.o_wr_addr       = wr_addr;
    assign bus.o_wr_data       = wr_data;
    assign bus.o_rs1_fwd_valid = f1_valid;
    assign bus.o_rs1_fwd_data  = f1_data;
    assign bus.o_rs2_fwd_valid = f2_valid;
    assign bus.o_rs2_fwd_data  = f2_data;
    assign bus.o_pending_mask  = pending;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, forwarding and reset
// sequences, then random traffic against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;

    logic clk;
    logic i_reset;

    wb_write_arbiter_if #(.XLEN(32)) bus ();

    wb_write_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: buffer as a queue, output register as three variables.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_wv;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic model_fwd(input logic [4:0] rs, output logic v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
        if (rs != 5'd0) begin
            if (m_wv && m_wa == rs) begin
                v = 1'b1;
                d = m_wd;
            end
            foreach (mq[i]) if (mq[i].rd == rs) begin
                v = 1'b1;
                d = mq[i].data;
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wv = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    // One cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic        fv;
        logic [31:0] fd;
        logic        acc;
        bus.i_alu_valid = av;
        bus.i_alu_rd    = ard;
        bus.i_alu_data  = ad;
        bus.i_ld_valid  = lv;
        bus.i_ld_rd     = lrd;
        bus.i_ld_data   = ldd;
        bus.i_rs1_addr  = r1;
        bus.i_rs2_addr  = r2;
        #1;
        model_fwd(r1, fv, fd);
        check("rs1_fwd_valid", 32'(bus.o_rs1_fwd_valid), 32'(fv));
        if (fv) check("rs1_fwd_data", bus.o_rs1_fwd_data, fd);
        model_fwd(r2, fv, fd);
        check("rs2_fwd_valid", 32'(bus.o_rs2_fwd_valid), 32'(fv));
        if (fv) check("rs2_fwd_data", bus.o_rs2_fwd_data, fd);
        acc = av && (mq.size() < DEPTH) && ard != 5'd0;
        @(posedge clk);
        if (lv && lrd != 5'd0) begin
            m_wv = 1'b1; m_wa = lrd; m_wd = ldd;
            if (acc) mq.push_back('{ard, ad});
        end else if (mq.size() > 0) begin
            m_wv = 1'b1; m_wa = mq[0].rd; m_wd = mq[0].data;
            void'(mq.pop_front());
            if (acc) mq.push_back('{ard, ad});
        end else if (acc) begin
            m_wv = 1'b1; m_wa = ard; m_wd = ad;
        end else begin
            m_wv = 1'b0;
        end
        #1;
        check("reg_write", 32'(bus.o_reg_write), 32'(m_wv));
        if (m_wv) begin
            check("wr_addr", 32'(bus.o_wr_addr), 32'(m_wa));
            check("wr_data", bus.o_wr_data, m_wd);
        end
        check("alu_ready", 32'(bus.o_alu_ready), 32'(mq.size() < DEPTH));
        check("pending_mask", bus.o_pending_mask, model_mask());
        @(negedge clk);
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        er;
        logic [31:0] em;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // av ard ad | lv lrd ld | expected after edge: wr addr data ready mask
        vecs.push_back('{1, 5, 32'hA5,   0, 0,  0,       1, 5,  32'hA5,   1, 32'h0});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       0, 0,  0,        1, 32'h0});
        vecs.push_back('{1, 7, 32'h22,   1, 6,  32'h11,  1, 6,  32'h11,   1, 32'h80});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       1, 7,  32'h22,   1, 32'h0});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       0, 0,  0,        1, 32'h0});
        vecs.push_back('{1, 0, 32'hFF,   0, 0,  0,       0, 0,  0,        1, 32'h0});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       0, 0,  0,        1, 32'h0});
        vecs.push_back('{1, 1, 32'h1001, 1, 10, 32'h100, 1, 10, 32'h100,  1, 32'h02});
        vecs.push_back('{1, 2, 32'h1002, 1, 11, 32'h101, 1, 11, 32'h101,  1, 32'h06});
        vecs.push_back('{1, 3, 32'h1003, 1, 12, 32'h102, 1, 12, 32'h102,  1, 32'h0E});
        vecs.push_back('{1, 4, 32'h1004, 1, 13, 32'h103, 1, 13, 32'h103,  0, 32'h1E});
        vecs.push_back('{1, 5, 32'h1005, 1, 14, 32'h104, 1, 14, 32'h104,  0, 32'h1E});
        vecs.push_back('{1, 5, 32'h1005, 1, 15, 32'h105, 1, 15, 32'h105,  0, 32'h1E});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       1, 1,  32'h1001, 1, 32'h1C});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       1, 2,  32'h1002, 1, 32'h18});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       1, 3,  32'h1003, 1, 32'h10});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       1, 4,  32'h1004, 1, 32'h00});
        vecs.push_back('{0, 0, 0,        0, 0,  0,       0, 0,  0,        1, 32'h00});

        i_reset         = 1'b1;
        bus.i_alu_valid = 1'b0;
        bus.i_alu_rd    = '0;
        bus.i_alu_data  = '0;
        bus.i_ld_valid  = 1'b0;
        bus.i_ld_rd     = '0;
        bus.i_ld_data   = '0;
        bus.i_rs1_addr  = 5'd5;
        bus.i_rs2_addr  = 5'd0;
        model_reset();
        #1;
        check("rst_reg_write", 32'(bus.o_reg_write), 32'd0);
        check("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        check("rst_wr_data", bus.o_wr_data, 32'd0);
        check("rst_mask", bus.o_pending_mask, 32'd0);
        check("rst_alu_ready", 32'(bus.o_alu_ready), 32'd1);
        check("rst_fwd1", 32'(bus.o_rs1_fwd_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;

        foreach (vecs[k]) begin
            step(vecs[k].av, vecs[k].ard, vecs[k].ad, vecs[k].lv, vecs[k].lrd, vecs[k].ld, 5'd0, 5'd0);
            check($sformatf("vec%0d_reg_write", k), 32'(bus.o_reg_write), 32'(vecs[k].ew));
            if (vecs[k].ew) begin
                check($sformatf("vec%0d_wr_addr", k), 32'(bus.o_wr_addr), 32'(vecs[k].ea));
                check($sformatf("vec%0d_wr_data", k), bus.o_wr_data, vecs[k].ed);
            end
            check($sformatf("vec%0d_alu_ready", k), 32'(bus.o_alu_ready), 32'(vecs[k].er));
            check($sformatf("vec%0d_mask", k), bus.o_pending_mask, vecs[k].em);
        end

        // Two buffered writes to rd 9; the youngest must win, buffer beats output reg.
        step(1, 9, 32'h44, 1, 3, 32'h1, 0, 0);
        step(1, 9, 32'h33, 1, 3, 32'h2, 0, 0);
        bus.i_rs1_addr = 5'd9;
        bus.i_rs2_addr = 5'd0;
        #1;
        check("fwd9_valid", 32'(bus.o_rs1_fwd_valid), 32'd1);
        check("fwd9_data", bus.o_rs1_fwd_data, 32'h33);
        check("fwd_rs0_valid", 32'(bus.o_rs2_fwd_valid), 32'd0);
        bus.i_rs1_addr = 5'd3;
        #1;
        check("fwd_outreg_valid", 32'(bus.o_rs1_fwd_valid), 32'd1);
        check("fwd_outreg_data", bus.o_rs1_fwd_data, 32'h2);
        step(0, 0, 0, 0, 0, 0, 9, 0);
        bus.i_rs1_addr = 5'd9;
        #1;
        check("fwd_young_over_out", bus.o_rs1_fwd_data, 32'h33);
        step(0, 0, 0, 0, 0, 0, 9, 9);
        step(0, 0, 0, 0, 0, 0, 9, 9);
        bus.i_rs1_addr = 5'd9;
        #1;
        check("fwd_after_commit", 32'(bus.o_rs1_fwd_valid), 32'd0);

        // Reset with three writes still buffered: none may ever reach the regfile.
        step(1, 21, 32'h210, 1, 20, 32'h200, 0, 0);
        step(1, 22, 32'h220, 1, 24, 32'h240, 0, 0);
        step(1, 23, 32'h230, 1, 25, 32'h250, 0, 0);
        check("pre_reset_mask", bus.o_pending_mask, 32'h00E0_0000);
        bus.i_alu_valid = 1'b0;
        bus.i_ld_valid  = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        check("midrst_reg_write", 32'(bus.o_reg_write), 32'd0);
        check("midrst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        check("midrst_wr_data", bus.o_wr_data, 32'd0);
        check("midrst_mask", bus.o_pending_mask, 32'd0);
        check("midrst_alu_ready", 32'(bus.o_alu_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 0, 0, 5'd21, 5'd23);
            check("post_rst_no_write", 32'(bus.o_reg_write), 32'd0);
        end

        // Random traffic; loads respect the pending mask as the issuer must.
        for (int c = 0; c < 400; c++) begin
            logic        av;
            logic        lv;
            logic [4:0]  ard;
            logic [4:0]  lrd;
            logic [31:0] pm;
            av  = ($urandom_range(0, 3) != 0);
            ard = 5'($urandom_range(0, 7));
            lv  = ($urandom_range(0, 2) == 0);
            lrd = 5'($urandom_range(0, 7));
            pm  = model_mask();
            for (int t = 0; t < 16 && pm[lrd]; t++) lrd = 5'($urandom_range(0, 7));
            if (pm[lrd]) lv = 1'b0;
            step(av, ard, $urandom, lv, lrd, $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
